cell_sweep_checker: RTL and testbench
=====================================

# cell_sweep_checker

Synthesizable stimulus sequencer and response checker that sits directly upstream and downstream of a 3-input standard cell (A, B1, B2 -> ZN) under test. It drives all eight input vectors in order {A,B1,B2} = 000..111 and holds each for a fixed settle time. At the end of each settle window it samples the cell output and compares it with a parameterized truth table. It reports a mismatch count, a per-vector failure mask and a pass flag, and replaces hand-written per-vector display benches.

## Interface
- `EXPECT`, default 8'h1F: expected ZN, where bit k is the value for vector k = {A,B1,B2}. The default is the OAI21 function ZN = !(A & (B1|B2)).
- `SETTLE`, default 10: cycles each vector is held before its sample is taken. Legal range 1..255.
- `clk`  in  1  sole clock. All state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a sweep. Sampled only in IDLE or DONE.
- `zn`  in  1  cell output under test.
- `a`  out  1  drives cell input A.
- `b1`  out  1  drives cell input B1.
- `b2`  out  1  drives cell input B2.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high in DONE. Held until the next start or reset.
- `pass`  out  1  valid when done=1. High iff err_count==0.
- `err_count`  out  4  number of mismatching vectors, 0..8.
- `fail_vec`  out  8  bit k set if vector k mismatched.

## Operation
- Registers: state, 3-bit vector index `vec`, 8-bit settle counter `cnt`, err_count, fail_vec.
- Output `{a,b1,b2}` = `vec` while in SWEEP, and 000 in IDLE and DONE.
- IDLE, start=1:
  - go to SWEEP with vec=0 and cnt=SETTLE-1.
  - clear err_count and fail_vec.
- SWEEP, cnt != 0: decrement cnt.
- SWEEP, cnt == 0: sample zn.
  - Mismatch is the 4-state inequality zn !== EXPECT[vec], so X and Z count as failures.
  - On mismatch, err_count += 1 and fail_vec[vec] = 1.
  - Then, if vec == 7, go to DONE. Otherwise vec += 1 and cnt = SETTLE-1.
- DONE:
  - done=1, and pass = (err_count==0).
  - start=1 behaves exactly like start in IDLE, including clearing results.
- start while in SWEEP is ignored and has no effect on the sweep.
- err_count cannot exceed 8, so no saturation logic is needed. The 4-bit width is sufficient.
- Reset values of all outputs: a=b1=b2=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. Internal state is IDLE, vec=0, cnt=0.
- Reset asserted mid-sweep aborts immediately and asynchronously. All outputs take their reset values and no partial results are retained.

## Timing
- Let E0 be the rising edge at which start is accepted.
- Vector k is driven from edge E0+k·SETTLE.
- Vector k is sampled at edge E0+(k+1)·SETTLE.
- busy is high from the cycle after E0 through the edge of the final sample.
- done and pass become visible after edge E0+8·SETTLE. Total sweep length is 8·SETTLE cycles.
- SETTLE=1: one vector per cycle, and zn is sampled at the same edge that advances vec. The cell path must settle within one clock period.
- Sampling is a single-cycle compare with no extra pipeline stage. err_count and fail_vec update at the sample edge.

## Configuration
- `CELL_SWEEP_LOG_EN` defined:
  - At every sample edge, print a simulation-only line `"%b%b%b: %b"` giving vec bits and zn.
  - On entry to DONE, print `PASS` or `FAIL n` with the err_count value.
- `CELL_SWEEP_LOG_EN` undefined: no display statements are compiled. Hardware behaviour is identical in both cases.

## Test plan
- Correct OAI21 model on zn, EXPECT=8'h1F, SETTLE=10, start pulse at E0 -> vectors change every 10 cycles; done at E0+80; pass=1, err_count=0, fail_vec=8'h00.
- zn tied to 0 -> err_count=5, fail_vec=8'h1F, pass=0.
- zn=X on vector 3 only (rest correct) -> err_count=1, fail_vec=8'h08, pass=0.
- SETTLE=1 with correct model -> a/b1/b2 step 000..111 on consecutive cycles; done at E0+8; pass=1.
- start re-pulsed mid-sweep, then rst_n low for 1 cycle at E0+35 -> mid-sweep start has no effect; on reset all outputs are 0 immediately; a fresh start after release gives a full clean 80-cycle sweep.
- Restart from DONE after a failing sweep, with the correct model -> err_count and fail_vec clear at the accept edge; the second sweep ends with pass=1.

Source files
------------

// File: rtl/cell_sweep_checker_if.sv
// Signal bundle between the sweep checker and whatever drives start and the cell output.
// master = stimulus/cell side, slave = the checker itself.
interface cell_sweep_checker_if;
    logic       start;
    logic       zn;
    logic       a;
    logic       b1;
    logic       b2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    modport master (
        output start, zn,
        input  a, b1, b2, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, zn,
        output a, b1, b2, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/cell_sweep_checker.sv
// Sweeps {A,B1,B2} through 000..111, samples ZN at the end of each settle window and
// checks it against EXPECT. Define CELL_SWEEP_LOG_EN for a simulation-only per-vector log.
module cell_sweep_checker #(
    parameter logic [7:0]  EXPECT = 8'h1F,
    parameter int unsigned SETTLE = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cell_sweep_checker_if.slave    bus
);

    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] vec_q,   vec_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [3:0] err_q,   err_d;
    logic [7:0] fail_q,  fail_d;
    logic       sample;
    logic       mismatch;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fail_d   = fail_q;
        sample   = (state_q == ST_SWEEP) && (cnt_q == 8'd0);
        // 4-state compare: an X or Z on the cell output is a failure, not a don't-care.
        mismatch = (bus.zn !== EXPECT[vec_q]);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SWEEP;
                    vec_d   = 3'd0;
                    cnt_d   = CNT_RELOAD;
                    err_d   = 4'd0;
                    fail_d  = 8'h00;
                end
            end
            ST_SWEEP: begin
                if (!sample) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (mismatch) begin
                        err_d         = err_q + 4'd1;
                        fail_d[vec_q] = 1'b1;
                    end
                    if (vec_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + 3'd1;
                        cnt_d = CNT_RELOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 8'd0;
            err_q   <= 4'd0;
            fail_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign {bus.a, bus.b1, bus.b2} = (state_q == ST_SWEEP) ? vec_q : 3'b000;
    assign bus.busy      = (state_q == ST_SWEEP);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (err_q == 4'd0);
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

`ifdef CELL_SWEEP_LOG_EN
    always @(posedge clk) begin
        if (rst_n && sample) begin
            $display("%b%b%b: %b", vec_q[2], vec_q[1], vec_q[0], bus.zn);
            if (vec_q == 3'd7) begin
                if (err_d == 4'd0) $display("PASS");
                else               $display("FAIL %0d", err_d);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_cell_sweep_checker.sv
// Scoreboard bench: stimulus pushes the expected end-of-sweep result, a monitor per
// instance pops and compares it when done rises. Two instances: SETTLE=10 and SETTLE=1.
module tb_cell_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   mode     = 0;   // 0 correct OAI21, 1 zn tied 0, 2 zn=X on vector 3

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    cell_sweep_checker_if if10 ();
    cell_sweep_checker_if if1 ();

    cell_sweep_checker #(.EXPECT(8'h1F), .SETTLE(10)) u10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if10.slave)
    );

    cell_sweep_checker #(.EXPECT(8'h1F), .SETTLE(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    function automatic logic cell_model(input int m, input logic a, input logic b1, input logic b2);
        logic good;
        good = ~(a & (b1 | b2));
        case (m)
            1:       return 1'b0;
            2:       return ({a, b1, b2} == 3'b011) ? 1'bx : good;
            default: return good;
        endcase
    endfunction

    assign if10.zn = cell_model(mode, if10.a, if10.b1, if10.b2);
    assign if1.zn  = cell_model(mode, if1.a,  if1.b1,  if1.b2);

    typedef struct {
        int         done_edge;
        logic [3:0] err;
        logic [7:0] fail;
        logic       pass;
    } exp_t;

    exp_t q10[$];
    exp_t q1[$];
    exp_t e10, e1;
    logic done10_prev = 1'b0;
    logic done1_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] outs10();
        return {if10.a, if10.b1, if10.b2, if10.busy, if10.done, if10.pass, if10.err_count, if10.fail_vec};
    endfunction

    function automatic logic [16:0] outs1();
        return {if1.a, if1.b1, if1.b2, if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_vec};
    endfunction

    // Monitors: compare the queued expectation when done rises.
    always @(negedge clk) begin
        if (if10.done && !done10_prev) begin
            if (q10.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u10_unexpected_done at edge %0d", edge_cnt);
            end else begin
                e10 = q10.pop_front();
                check("u10_done_edge", edge_cnt,        e10.done_edge);
                check("u10_err_count", if10.err_count,  e10.err);
                check("u10_fail_vec",  if10.fail_vec,   e10.fail);
                check("u10_pass",      if10.pass,       e10.pass);
            end
        end
        done10_prev = if10.done;
    end

    always @(negedge clk) begin
        if (if1.done && !done1_prev) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_unexpected_done at edge %0d", edge_cnt);
            end else begin
                e1 = q1.pop_front();
                check("u1_done_edge", edge_cnt,       e1.done_edge);
                check("u1_err_count", if1.err_count,  e1.err);
                check("u1_fail_vec",  if1.fail_vec,   e1.fail);
                check("u1_pass",      if1.pass,       e1.pass);
            end
        end
        done1_prev = if1.done;
    end

    task automatic wait_edge(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic start10(output int e0);
        @(negedge clk);
        if10.start = 1'b1;
        @(negedge clk);
        if10.start = 1'b0;
        e0 = edge_cnt;
    endtask

    task automatic start1(output int e0);
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        e0 = edge_cnt;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && (q10.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        checks++;
        if (q10.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: pending %0d/%0d expected 0/0", name, q10.size(), q1.size());
        end
    endtask

    task automatic check_vec10(input string name, input int e0, input int n, input logic [2:0] v);
        wait_edge(e0 + n);
        check(name, {if10.a, if10.b1, if10.b2, if10.busy}, {v, 1'b1});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_n      = 1'b0;
        if10.start = 1'b0;
        if1.start  = 1'b0;
        mode       = 0;
        repeat (2) @(negedge clk);
        check("reset_u10", outs10(), 17'h0);
        check("reset_u1",  outs1(),  17'h0);
        rst_n = 1'b1;

        // Correct model, SETTLE=10: vectors change every 10 cycles, clean pass at E0+80.
        start10(e0);
        q10.push_back('{e0 + 80, 4'd0, 8'h00, 1'b1});
        check("t1_vec0", {if10.a, if10.b1, if10.b2, if10.busy}, {3'b000, 1'b1});
        check_vec10("t1_vec0_end", e0, 9,  3'b000);
        check_vec10("t1_vec1",     e0, 10, 3'b001);
        check_vec10("t1_vec2",     e0, 25, 3'b010);
        check_vec10("t1_vec7",     e0, 79, 3'b111);
        drain("t1");

        // zn tied 0: vectors 0..4 expect 1 -> five failures.
        mode = 1;
        start10(e0);
        q10.push_back('{e0 + 80, 4'd5, 8'h1F, 1'b0});
        drain("t2");

        // X on vector 3 only.
        mode = 2;
        start10(e0);
        q10.push_back('{e0 + 80, 4'd1, 8'h08, 1'b0});
        drain("t3");

        // Restart from a failing DONE with the correct model: results clear at the accept edge.
        mode = 0;
        start10(e0);
        q10.push_back('{e0 + 80, 4'd0, 8'h00, 1'b1});
        check("t6_cleared", {if10.busy, if10.done, if10.pass, if10.err_count, if10.fail_vec},
              {1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
        drain("t6");

        // SETTLE=1: one vector per cycle, done at E0+8.
        start1(e0);
        q1.push_back('{e0 + 8, 4'd0, 8'h00, 1'b1});
        for (int k = 0; k < 8; k++) begin
            wait_edge(e0 + k);
            check($sformatf("t4_vec%0d", k), {if1.a, if1.b1, if1.b2, if1.busy}, {3'(k), 1'b1});
        end
        drain("t4");

        // Mid-sweep start ignored, then async reset at E0+35, then a fresh clean sweep.
        start10(e0);
        wait_edge(e0 + 14);
        if10.start = 1'b1;
        @(negedge clk);
        if10.start = 1'b0;
        check_vec10("t5_vec2_after_restart", e0, 20, 3'b010);
        check_vec10("t5_vec3",               e0, 35, 3'b011);
        rst_n = 1'b0;
        #1;
        check("t5_async_reset_u10", outs10(), 17'h0);
        check("t5_async_reset_u1",  outs1(),  17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_idle_after_reset", outs10(), 17'h0);
        start10(e0);
        q10.push_back('{e0 + 80, 4'd0, 8'h00, 1'b1});
        check_vec10("t5_fresh_vec0", e0, 5,  3'b000);
        check_vec10("t5_fresh_vec7", e0, 79, 3'b111);
        drain("t5");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
